// File: rtl/fairy_mem_access_pkg.sv
// Shared definitions for the fairy memory-access stage: load/store opcodes,
// data-bus size encodings, FSM states and the memory-op decoder.
package fairy_mem_access_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } dsize_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic   is_mem;
        logic   is_store;
        logic   sign_ext;
        dsize_e size;
    } mem_op_t;

    // Anything outside the eight load/store opcodes is a pass-through instruction.
    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        mem_op_t op;
        op.is_mem   = 1'b1;
        op.is_store = 1'b0;
        op.sign_ext = 1'b0;
        op.size     = SIZE_WORD;
        case (opcode)
            OP_LB:  begin op.sign_ext = 1'b1; op.size = SIZE_BYTE; end
            OP_LBU: op.size = SIZE_BYTE;
            OP_LH:  begin op.sign_ext = 1'b1; op.size = SIZE_HALF; end
            OP_LHU: op.size = SIZE_HALF;
            OP_LW:  op.size = SIZE_WORD;
            OP_SB:  begin op.is_store = 1'b1; op.size = SIZE_BYTE; end
            OP_SH:  begin op.is_store = 1'b1; op.size = SIZE_HALF; end
            OP_SW:  op.is_store = 1'b1;
            default: op.is_mem = 1'b0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fairy_mem_access_if.sv
// Data-SRAM request/response bus between the memory-access stage (master)
// and the SRAM controller (slave).
interface fairy_mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dreq;
    logic              dwr;
    logic [1:0]        dsize;
    logic [ADDR_W-1:0] daddr;
    logic [3:0]        dwstrb;
    logic [DATA_W-1:0] dwdata;
    logic              daddr_ok;
    logic              ddata_ok;
    logic [DATA_W-1:0] drdata;

    modport master (
        output dreq, dwr, dsize, daddr, dwstrb, dwdata,
        input  daddr_ok, ddata_ok, drdata
    );

    modport slave (
        input  dreq, dwr, dsize, daddr, dwstrb, dwdata,
        output daddr_ok, ddata_ok, drdata
    );
endinterface

// File: rtl/fairy_mem_access_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends
// it to 32 bits; words pass through untouched.
module fairy_mem_access_load_align
    import fairy_mem_access_pkg::*;
(
    input  logic [31:0] drdata,
    input  logic [1:0]  addr,
    input  dsize_e      size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = drdata[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? drdata[31:16] : drdata[15:0];
        case (size)
            SIZE_BYTE: result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SIZE_HALF: result = {{16{sign_ext & half_lane[15]}}, half_lane};
            default:   result = drdata;
        endcase
    end

endmodule

// File: rtl/fairy_mem_access.sv
// Memory-access stage of the fairy MIPS pipeline: issues one data-bus
// transaction per load/store, formats stores, aligns loads, retires to write-back.
module fairy_mem_access
    import fairy_mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_reg_waddr,
    input  logic        in_reg_we,
    input  logic        in_fault,
    fairy_mem_access_if.master dbus,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_reg_waddr,
    output logic        out_reg_we
);

    state_e            state;
    mem_op_t           dec;
    logic [3:0]        store_strb;
    logic [DATA_W-1:0] store_data;
    logic [31:0]       load_data;
    logic              resp_done;

    logic       lat_is_store;
    logic       lat_sign;
    dsize_e     lat_size;
    logic [1:0] lat_addr;
    logic [4:0] lat_waddr;
    logic       lat_we;

    logic unused_inst_bits;
    assign unused_inst_bits = ^in_inst[25:0];

    assign dec      = decode_mem_op(in_inst[31:26]);
    assign in_ready = (state == ST_IDLE);

    // A response counts in REQ only alongside the address handshake, since
    // nothing else can be outstanding.
    assign resp_done = dbus.ddata_ok &&
                       ((state == ST_WAIT) || ((state == ST_REQ) && dbus.daddr_ok));

    always_comb begin
        store_strb = 4'b0000;
        store_data = '0;
        if (dec.is_store) begin
            case (dec.size)
                SIZE_BYTE: begin
                    store_strb = 4'b0001 << in_addr[1:0];
                    store_data = {4{in_wdata[7:0]}};
                end
                SIZE_HALF: begin
                    store_strb = in_addr[1] ? 4'b1100 : 4'b0011;
                    store_data = {2{in_wdata[15:0]}};
                end
                default: begin
                    store_strb = 4'b1111;
                    store_data = in_wdata;
                end
            endcase
        end
    end

    fairy_mem_access_load_align u_load_align (
        .drdata   (dbus.drdata),
        .addr     (lat_addr),
        .size     (lat_size),
        .sign_ext (lat_sign),
        .result   (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            dbus.dreq     <= 1'b0;
            dbus.dwr      <= 1'b0;
            dbus.dsize    <= 2'd0;
            dbus.daddr    <= '0;
            dbus.dwstrb   <= 4'b0000;
            dbus.dwdata   <= '0;
            out_valid     <= 1'b0;
            out_data      <= 32'd0;
            out_reg_waddr <= 5'd0;
            out_reg_we    <= 1'b0;
            lat_is_store  <= 1'b0;
            lat_sign      <= 1'b0;
            lat_size      <= SIZE_BYTE;
            lat_addr      <= 2'd0;
            lat_waddr     <= 5'd0;
            lat_we        <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (resp_done && !flush) begin
                out_valid     <= 1'b1;
                out_reg_waddr <= lat_waddr;
                out_reg_we    <= lat_we & ~lat_is_store;
                if (!lat_is_store) begin
                    out_data <= load_data;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (in_valid && !flush) begin
                        if (dec.is_mem && !in_fault) begin
                            lat_is_store <= dec.is_store;
                            lat_sign     <= dec.sign_ext;
                            lat_size     <= dec.size;
                            lat_addr     <= in_addr[1:0];
                            lat_waddr    <= in_reg_waddr;
                            lat_we       <= in_reg_we;
                            dbus.dreq    <= 1'b1;
                            dbus.dwr     <= dec.is_store;
                            dbus.dsize   <= dec.size;
                            dbus.daddr   <= in_addr[ADDR_W-1:0];
                            dbus.dwstrb  <= store_strb;
                            dbus.dwdata  <= store_data;
                            state        <= ST_REQ;
                        end else begin
                            out_valid     <= 1'b1;
                            out_data      <= in_addr;
                            out_reg_waddr <= in_reg_waddr;
                            out_reg_we    <= in_reg_we & ~in_fault;
                        end
                    end
                end
                ST_REQ: begin
                    if (dbus.daddr_ok) begin
                        dbus.dreq <= 1'b0;
                        if (dbus.ddata_ok) begin
                            state <= ST_IDLE;
                        end else if (flush) begin
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (flush) begin
                        dbus.dreq <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dbus.ddata_ok) begin
                        state <= ST_IDLE;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dbus.ddata_ok) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fairy_mem_access.sv
// Randomized bench for fairy_mem_access: an in-bench bus responder drives
// handshake timing and a byte-lane reference model predicts every result.
module tb_fairy_mem_access;
    import fairy_mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_reg_waddr;
    logic        in_reg_we;
    logic        in_fault;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_reg_waddr;
    logic        out_reg_we;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fairy_mem_access_if dbus ();

    fairy_mem_access dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_reg_waddr  (in_reg_waddr),
        .in_reg_we     (in_reg_we),
        .in_fault      (in_fault),
        .dbus          (dbus),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_reg_waddr (out_reg_waddr),
        .out_reg_we    (out_reg_we)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: access width in bytes, then plain shift/mask arithmetic.
    function automatic bit isMemOp(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit isStoreOp(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic int unsigned accessBytes(input logic [5:0] op);
        if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
        if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [5:0] op, input logic [31:0] word, input int unsigned a);
        int unsigned v;
        case (accessBytes(op))
            1: begin
                v = (word >> (8 * a)) & 32'hFF;
                if (op == OP_LB && v >= 128) v = v + 32'hFFFFFF00;
            end
            2: begin
                v = (word >> (16 * (a / 2))) & 32'hFFFF;
                if (op == OP_LH && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] refStrobe(input logic [5:0] op, input int unsigned a);
        if (!isStoreOp(op)) return 0;
        case (accessBytes(op))
            1: return 32'd1 << a;
            2: return (a >= 2) ? 32'hC : 32'h3;
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] refWdata(input logic [5:0] op, input logic [31:0] rt);
        case (accessBytes(op))
            1: return (rt & 32'hFF) * 32'h01010101;
            2: return (rt & 32'hFFFF) * 32'h00010001;
            default: return rt;
        endcase
    endfunction

    function automatic logic [31:0] refSize(input logic [5:0] op);
        case (accessBytes(op))
            1: return 0;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] makeInst(input logic [5:0] op);
        if (op == 6'h00) return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        return {op, 5'd4, 5'd5, 16'h0010};
    endfunction

    // flushAt: 0 none, 1 in REQ before daddr_ok, 2 in first WAIT cycle, 3 with the input in IDLE.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                 input logic [4:0] waddr, input logic we, input logic fault,
                                 input int addrDelay, input int dataDelay, input int flushAt,
                                 input logic [31:0] rdata);
        bit mem = isMemOp(op) && !fault;
        bit st = isStoreOp(op);
        bit flushed = 1'b0;
        int unsigned a = int'(addr[1:0]);
        if (flushAt == 1 && addrDelay < 1) addrDelay = 1;
        if (flushAt == 2 && dataDelay < 1) dataDelay = 1;

        checkOutput("ready_idle", in_ready, 1);
        in_valid     = 1'b1;
        in_inst      = makeInst(op);
        in_addr      = addr;
        in_wdata     = rt;
        in_reg_waddr = waddr;
        in_reg_we    = we;
        in_fault     = fault;
        flush        = (flushAt == 3);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;

        if (flushAt == 3) begin
            checkOutput("flush_idle_valid", out_valid, 0);
            checkOutput("flush_idle_dreq", dbus.dreq, 0);
            return;
        end
        if (!mem) begin
            checkOutput("pass_valid", out_valid, 1);
            checkOutput("pass_data", out_data, addr);
            checkOutput("pass_we", out_reg_we, we & ~fault);
            checkOutput("pass_waddr", out_reg_waddr, waddr);
            checkOutput("pass_dreq", dbus.dreq, 0);
            return;
        end

        checkOutput("req_dreq", dbus.dreq, 1);
        checkOutput("req_dwr", dbus.dwr, st);
        checkOutput("req_dsize", dbus.dsize, refSize(op));
        checkOutput("req_daddr", dbus.daddr, addr);
        checkOutput("req_dwstrb", dbus.dwstrb, refStrobe(op, a));
        if (st) checkOutput("req_dwdata", dbus.dwdata, refWdata(op, rt));
        checkOutput("req_ready", in_ready, 0);

        for (int i = 0; i < addrDelay; i++) begin
            flush = (flushAt == 1 && i == 0);
            @(negedge clk);
            flush = 1'b0;
            if (flushAt == 1) begin
                checkOutput("flush_req_dreq", dbus.dreq, 0);
                checkOutput("flush_req_ready", in_ready, 1);
                checkOutput("flush_req_valid", out_valid, 0);
                return;
            end
            checkOutput("hold_dreq", dbus.dreq, 1);
            checkOutput("hold_daddr", dbus.daddr, addr);
            if (st) checkOutput("hold_dwdata", dbus.dwdata, refWdata(op, rt));
            checkOutput("hold_ready", in_ready, 0);
        end

        dbus.daddr_ok = 1'b1;
        if (dataDelay == 0) begin
            dbus.ddata_ok = 1'b1;
            dbus.drdata   = rdata;
        end
        @(negedge clk);
        dbus.daddr_ok = 1'b0;
        dbus.ddata_ok = 1'b0;

        if (dataDelay > 0) begin
            checkOutput("wait_dreq", dbus.dreq, 0);
            for (int j = 1; j <= dataDelay; j++) begin
                if (flushAt == 2 && j == 1) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
                if (j == dataDelay) begin
                    dbus.ddata_ok = 1'b1;
                    dbus.drdata   = rdata;
                end else begin
                    dbus.drdata = $urandom;
                end
                @(negedge clk);
                flush         = 1'b0;
                dbus.ddata_ok = 1'b0;
                if (flushed && j < dataDelay) begin
                    checkOutput("drain_ready", in_ready, 0);
                    checkOutput("drain_dreq", dbus.dreq, 0);
                    checkOutput("drain_valid", out_valid, 0);
                end
            end
        end

        if (flushed) begin
            checkOutput("flushed_valid", out_valid, 0);
            checkOutput("flushed_ready", in_ready, 1);
            checkOutput("flushed_dreq", dbus.dreq, 0);
            return;
        end

        checkOutput("retire_valid", out_valid, 1);
        checkOutput("retire_we", out_reg_we, st ? 1'b0 : we);
        checkOutput("retire_waddr", out_reg_waddr, waddr);
        if (!st) checkOutput("retire_data", out_data, refLoad(op, rdata, a));
        checkOutput("retire_ready", in_ready, 1);
        @(negedge clk);
        checkOutput("pulse_end", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] opTable [9];
        opTable = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 6'h00};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_addr = '0;
        in_wdata = '0; in_reg_waddr = '0; in_reg_we = 1'b0; in_fault = 1'b0;
        dbus.daddr_ok = 1'b0; dbus.ddata_ok = 1'b0; dbus.drdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_dreq", dbus.dreq, 0);
        checkOutput("rst_dwr", dbus.dwr, 0);
        checkOutput("rst_dsize", dbus.dsize, 0);
        checkOutput("rst_daddr", dbus.daddr, 0);
        checkOutput("rst_dwstrb", dbus.dwstrb, 0);
        checkOutput("rst_dwdata", dbus.dwdata, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_waddr", out_reg_waddr, 0);
        checkOutput("rst_out_we", out_reg_we, 0);
        checkOutput("rst_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(OP_SW, 32'h10000004, 32'hDEADBEEF, 5'd7, 1'b0, 1'b0, 0, 1, 0, 32'h0);
        applyStimulus(OP_LB,  32'h10000003, 32'h0, 5'd8,  1'b1, 1'b0, 0, 1, 0, 32'h80FF1234);
        applyStimulus(OP_LBU, 32'h10000003, 32'h0, 5'd9,  1'b1, 1'b0, 0, 0, 0, 32'h80FF1234);
        applyStimulus(OP_LH,  32'h10000002, 32'h0, 5'd10, 1'b1, 1'b0, 1, 2, 0, 32'h80FF1234);
        applyStimulus(OP_LHU, 32'h10000002, 32'h0, 5'd11, 1'b1, 1'b0, 0, 1, 0, 32'h80FF1234);
        applyStimulus(OP_LW,  32'h10000000, 32'h0, 5'd12, 1'b1, 1'b0, 0, 1, 0, 32'h80FF1234);
        applyStimulus(OP_SB, 32'h10000001, 32'h000000AB, 5'd0, 1'b0, 1'b0, 0, 1, 0, 32'h0);
        applyStimulus(OP_SH, 32'h10000002, 32'h00001234, 5'd0, 1'b0, 1'b0, 0, 1, 0, 32'h0);
        applyStimulus(OP_LW, 32'h20000010, 32'h0, 5'd13, 1'b1, 1'b0, 3, 1, 0, 32'hCAFEF00D);
        applyStimulus(OP_LW, 32'h20000020, 32'h0, 5'd14, 1'b1, 1'b0, 0, 3, 2, 32'h12345678);
        applyStimulus(OP_LW, 32'h20000030, 32'h0, 5'd15, 1'b1, 1'b0, 2, 1, 1, 32'h12345678);
        applyStimulus(OP_LW, 32'h20000040, 32'h0, 5'd16, 1'b1, 1'b0, 0, 1, 3, 32'h12345678);

        // Three ADDUs issued on consecutive cycles must retire on consecutive cycles.
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) begin
                in_valid = 1'b1; in_inst = makeInst(6'h00); in_addr = k;
                in_reg_waddr = 5'(k); in_reg_we = 1'b1; in_fault = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k <= 3) begin
                checkOutput("addu_valid", out_valid, 1);
                checkOutput("addu_data", out_data, k);
                checkOutput("addu_dreq", dbus.dreq, 0);
            end
        end
        applyStimulus(OP_LW, 32'h10000000, 32'h0, 5'd17, 1'b1, 1'b1, 0, 1, 0, 32'h0);

        // Reset while a request is pending abandons it.
        in_valid = 1'b1; in_inst = makeInst(OP_LW); in_addr = 32'h30000000; in_fault = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rstmid_dreq_before", dbus.dreq, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstmid_dreq", dbus.dreq, 0);
        checkOutput("rstmid_ready", in_ready, 1);
        checkOutput("rstmid_valid", out_valid, 0);
        @(negedge clk);

        $display("[TB] randomized cases");
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            int fsel;
            op = opTable[$urandom_range(0, 8)];
            fsel = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
            applyStimulus(op, $urandom, $urandom, 5'($urandom_range(1, 31)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fsel, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fairy_mem_access.md
Name: fairy_mem_access

Overview:
Memory-access stage of the fairy MIPS pipeline. It consumes the registered execute-stage results: ALU result/effective address, rt store data, instruction word, and destination register. For LB/LBU/LH/LHU/LW/SB/SH/SW it issues one transaction on the data-SRAM request/response bus. It formats store byte lanes, aligns and extends load data, and hands a registered result to write-back. Non-memory instructions pass through with 1-cycle latency.

Parameters:
ADDR_W, 32, data-bus address width
DATA_W, 32, data-bus width; only 32 is supported

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
flush  in  1  exception/eret kill; discards the in-flight instruction
in_valid  in  1  execute-stage result valid
in_ready  out  1  stage can accept; 1 only in IDLE
in_inst  in  32  instruction word
in_addr  in  32  ALU result / effective address
in_wdata  in  32  rt value (store data)
in_reg_waddr  in  5  destination register
in_reg_we  in  1  register write enable
in_fault  in  1  unaligned/overflow/illegal already flagged; suppresses the bus access
dreq  out  1  bus request
dwr  out  1  1 = store
dsize  out  2  0 byte, 1 half, 2 word
daddr  out  32  byte address (= in_addr)
dwstrb  out  4  byte write strobes; 0 for loads
dwdata  out  32  lane-replicated store data
daddr_ok  in  1  request accepted this cycle
ddata_ok  in  1  response/write-ack this cycle
drdata  in  32  read word, valid with ddata_ok
out_valid  out  1  one-cycle pulse per retired instruction
out_data  out  32  write-back value
out_reg_waddr  out  5  destination register
out_reg_we  out  1  write enable, qualified

Behaviour:
- Reset: state=IDLE. dreq, dwr, dwstrb, out_valid and out_reg_we are 0. dsize, daddr, dwdata, out_data and out_reg_waddr are 0.
- States:
  - IDLE: in_ready=1.
  - REQ: dreq=1 and bus outputs held stable.
  - WAIT: waiting for ddata_ok.
  - DRAIN: a flushed access is still outstanding.
- IDLE, accepting in_valid & ~flush:
  - Non-memory instruction, or memory op with in_fault=1: register the result, out_valid=1 next cycle, state stays IDLE.
    - out_data = in_addr.
    - out_reg_we = in_reg_we & ~in_fault.
  - Memory op with in_fault=0: latch inst class, addr[1:0] and destination; go to REQ next cycle.
- REQ:
  - daddr_ok=1 and ddata_ok=0 -> WAIT.
  - daddr_ok=1 and ddata_ok=1 (same-cycle response) -> retire.
  - daddr_ok=0 -> stay; all bus outputs stay unchanged.
- WAIT: ddata_ok=1 -> retire.
- Retire: next cycle out_valid=1 and state IDLE.
  - Loads: out_data = aligned drdata, out_reg_we = latched in_reg_we.
  - Stores: out_reg_we = 0.
- Store formatting:
  - SW: dwstrb=1111, dwdata=rt.
  - SH: dwstrb=addr[1] ? 1100 : 0011, dwdata={2{rt[15:0]}}.
  - SB: dwstrb=0001<<addr[1:0], dwdata={4{rt[7:0]}}.
- Load alignment:
  - Byte: drdata>>(8*addr[1:0]), then [7:0] sign-extended (LB) or zero-extended (LBU).
  - Half: lane addr[1], sign-extended (LH) or zero-extended (LHU).
  - LW: full word.
- Flush:
  - In IDLE: input ignored; no out_valid next cycle.
  - In REQ with daddr_ok=0: dreq drops next cycle, go to IDLE.
  - In REQ with daddr_ok=1 (no same-cycle ddata_ok), or in WAIT without ddata_ok: go to DRAIN.
  - In REQ or WAIT with ddata_ok=1 the same cycle: go to IDLE.
  - Every flushed access: out_valid suppressed.
- DRAIN: in_ready=0 and dreq=0. ddata_ok -> IDLE; the response is discarded.
- At most one outstanding bus transaction, ever.
- reset has priority over flush; reset mid-transaction returns to IDLE. The bus responder shares the same reset.
- No back-pressure from write-back: out_valid is a one-cycle pulse, out_* held until the next retire.

Decomposition:
- fairy_pkg holds:
  - opcode constants for LB/LBU/LH/LHU/LW/SB/SH/SW;
  - dsize encodings;
  - FSM state encoding (IDLE, REQ, WAIT, DRAIN).
- One combinational sub-module, fairy_load_align: inputs drdata, addr[1:0], size, signed; output 32-bit aligned result.
- Store formatting and the FSM stay in the top module.

Test Plan:
1. SW, addr 0x10000004, rt 0xDEADBEEF, daddr_ok in the first REQ cycle, ddata_ok 1 cycle later -> dreq=1, dwr=1, dsize=2, dwstrb=1111, dwdata=0xDEADBEEF; one out_valid with out_reg_we=0.
2. drdata 0x80FF1234 returned for:
   - LB addr ..3 -> out_data 0xFFFFFF80
   - LBU addr ..3 -> 0x00000080
   - LH addr ..2 -> 0xFFFF80FF
   - LHU addr ..2 -> 0x000080FF
   - LW -> 0x80FF1234
3. SB addr ..1, rt 0x000000AB -> dwstrb 0010, dwdata 0xABABABAB. SH addr ..2, rt 0x00001234 -> dwstrb 1100, dwdata 0x12341234.
4. daddr_ok held 0 for 3 cycles -> dreq, daddr and dwdata stable throughout, in_ready=0; retire 1 cycle after ddata_ok.
5. flush asserted in WAIT, ddata_ok 2 cycles later -> DRAIN, no out_valid, dreq=0, in_ready=1 the cycle after ddata_ok. Repeat with flush in REQ before daddr_ok -> dreq=0 next cycle, immediate IDLE.
6. Three back-to-back ADDU, in_addr 1/2/3 -> out_valid 3 consecutive cycles, out_data 1,2,3, latency 1, dreq never asserted. LW with in_fault=1 -> no dreq, out_valid with out_reg_we=0.
